decoder_scan: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with enable, extending the lab's 2-to-4 decoder with two modes. In direct mode it decodes a select input; in scan mode it walks its output across all lines on its own, holding each line for a programmable number of cycles. It drives multiplexed displays and keypad column strobes in later lab stages, and can also serve as a plain registered decoder.

---
 rtl/decoder_scan_pkg.sv | 13 +
 rtl/decoder_scan_if.sv | 20 ++
 rtl/decoder_scan_onehot_decoder.sv | 19 +
 rtl/decoder_scan.sv | 91 +++++++++
 tb/tb_decoder_scan.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared mode and state encodings for the scanning one-hot decoder.
package decoder_scan_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

endpackage

// File: rtl/decoder_scan_if.sv
// Control/result bundle between a driver and decoder_scan.
//   enable, mode, sel, load : driver -> decoder
//   out, idx, wrap          : decoder -> driver (registered)
interface decoder_scan_if #(
   parameter int unsigned SEL_W = 2
);
   localparam int unsigned N_LINES = 1 << SEL_W;

   logic               enable;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic               load;
   logic [N_LINES-1:0] out;
   logic [SEL_W-1:0]   idx;
   logic               wrap;

   modport master (output enable, mode, sel, load, input out, idx, wrap);
   modport slave  (input enable, mode, sel, load, output out, idx, wrap);

endinterface

// File: rtl/decoder_scan_onehot_decoder.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
//   sel    : line number
//   en     : 0 forces all lines low
//   onehot : 1 << sel when enabled, else zero
module onehot_decoder #(
   parameter int unsigned SEL_W = 2
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic                    en,
   output logic [(1<<SEL_W)-1:0]   onehot
);
   localparam int unsigned N_LINES = 1 << SEL_W;

   always_comb begin
      onehot = '0;
      if (en) onehot = N_LINES'(1) << sel;
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct-decode and self-scanning modes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : enable/mode/sel/load in; out/idx/wrap registered out
// In scan mode each line is held for DWELL cycles; load re-points the scan.
module decoder_scan
   import decoder_scan_pkg::*;
#(
   parameter int unsigned SEL_W = 2,
   parameter int unsigned DWELL = 4
) (
   input  logic           clk,
   input  logic           rst,
   decoder_scan_if.slave  bus
);
   localparam int unsigned    N_LINES  = 1 << SEL_W;
   localparam int unsigned    CNT_W    = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_LINES - 1);

   state_t             st, st_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [SEL_W-1:0]   idx_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               wrap_nxt;
   logic               dec_en;
   logic [N_LINES-1:0] onehot;

   // Next state and next datapath values; actions follow the state being entered.
   always_comb begin
      st_nxt   = ST_IDLE;
      ptr_nxt  = ptr;
      cnt_nxt  = cnt;
      idx_nxt  = bus.idx;
      wrap_nxt = 1'b0;
      if (bus.enable) st_nxt = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;

      case (st_nxt)
         ST_DIRECT: begin
            ptr_nxt = bus.sel;
            cnt_nxt = '0;
            idx_nxt = bus.sel;
         end
         ST_SCAN: begin
            if (bus.load) begin
               // load wins over advance, and never reports a wrap
               ptr_nxt = bus.sel;
               cnt_nxt = '0;
            end else if (st != ST_SCAN) begin
               // resume on the current line with a fresh dwell
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               ptr_nxt  = ptr + SEL_W'(1);
               cnt_nxt  = '0;
               wrap_nxt = (ptr == PTR_LAST);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
            idx_nxt = ptr_nxt;
         end
         default: ;
      endcase
   end

   assign dec_en = (st_nxt != ST_IDLE);

   onehot_decoder #(.SEL_W(SEL_W)) u_dec (
      .sel    (ptr_nxt),
      .en     (dec_en),
      .onehot (onehot)
   );

   // State, scan pointer, dwell counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= ST_IDLE;
         ptr      <= '0;
         cnt      <= '0;
         bus.out  <= '0;
         bus.idx  <= '0;
         bus.wrap <= 1'b0;
      end else begin
         st       <= st_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         bus.out  <= onehot;
         bus.idx  <= idx_nxt;
         bus.wrap <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: SEL_W=2/DWELL=4 and SEL_W=3/DWELL=1,
// directed steps followed by random stimulus against a line/dwell model.
module tb_decoder_scan;

   logic clk;
   logic rst;

   decoder_scan_if #(.SEL_W(2)) bus2 ();
   decoder_scan_if #(.SEL_W(3)) bus3 ();

   decoder_scan #(.SEL_W(2), .DWELL(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   decoder_scan #(.SEL_W(3), .DWELL(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // stimulus per instance (0 -> bus2, 1 -> bus3)
   int d_en[2], d_mode[2], d_sel[2], d_load[2];

   // model: which line is shown, for how many cycles so far, and whether scanning
   int       m_line[2], m_held[2], m_idx[2];
   bit       m_scan[2];
   logic [7:0] exp_out[2];
   int       exp_idx[2];
   bit       exp_wrap[2];

   function automatic int nlines(input int d);
      return (d == 0) ? 4 : 8;
   endfunction

   function automatic int dwell(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_line[d] = 0; m_held[d] = 0; m_idx[d] = 0; m_scan[d] = 1'b0;
         exp_out[d] = 8'h00; exp_idx[d] = 0; exp_wrap[d] = 1'b0;
      end
   endtask

   task automatic model_step(input int d);
      exp_wrap[d] = 1'b0;
      if (d_en[d] == 0) begin
         exp_out[d] = 8'h00;
         m_scan[d]  = 1'b0;
      end else if (d_mode[d] == 0) begin
         m_line[d]  = d_sel[d];
         m_idx[d]   = m_line[d];
         exp_out[d] = 8'(1 << m_line[d]);
         m_scan[d]  = 1'b0;
      end else begin
         if (d_load[d] != 0) begin
            m_line[d] = d_sel[d];
            m_held[d] = 1;
         end else if (!m_scan[d]) begin
            m_held[d] = 1;
         end else if (m_held[d] >= dwell(d)) begin
            m_line[d]   = (m_line[d] + 1) % nlines(d);
            m_held[d]   = 1;
            exp_wrap[d] = (m_line[d] == 0);
         end else begin
            m_held[d] = m_held[d] + 1;
         end
         m_scan[d]  = 1'b1;
         m_idx[d]   = m_line[d];
         exp_out[d] = 8'(1 << m_line[d]);
      end
      exp_idx[d] = m_idx[d];
   endtask

   task automatic set_in(input int d, input int en, input int mode, input int sel, input int load);
      d_en[d] = en; d_mode[d] = mode; d_sel[d] = sel; d_load[d] = load;
   endtask

   task automatic drive();
      bus2.enable = 1'(d_en[0]); bus2.mode = 1'(d_mode[0]);
      bus2.sel    = 2'(d_sel[0]); bus2.load = 1'(d_load[0]);
      bus3.enable = 1'(d_en[1]); bus3.mode = 1'(d_mode[1]);
      bus3.sel    = 3'(d_sel[1]); bus3.load = 1'(d_load[1]);
   endtask

   task automatic check_outputs(input string tag);
      checks++;
      assert (8'(bus2.out) === exp_out[0]) else begin
         errors++; $error("FAIL %s out(w2) got %b want %b", tag, bus2.out, exp_out[0]);
      end
      checks++;
      assert (32'(bus2.idx) === exp_idx[0]) else begin
         errors++; $error("FAIL %s idx(w2) got %0d want %0d", tag, bus2.idx, exp_idx[0]);
      end
      checks++;
      assert (bus2.wrap === exp_wrap[0]) else begin
         errors++; $error("FAIL %s wrap(w2) got %b want %b", tag, bus2.wrap, exp_wrap[0]);
      end
      checks++;
      assert (8'(bus3.out) === exp_out[1]) else begin
         errors++; $error("FAIL %s out(w3) got %b want %b", tag, bus3.out, exp_out[1]);
      end
      checks++;
      assert (32'(bus3.idx) === exp_idx[1]) else begin
         errors++; $error("FAIL %s idx(w3) got %0d want %0d", tag, bus3.idx, exp_idx[1]);
      end
      checks++;
      assert (bus3.wrap === exp_wrap[1]) else begin
         errors++; $error("FAIL %s wrap(w3) got %b want %b", tag, bus3.wrap, exp_wrap[1]);
      end
   endtask

   // inputs change on the falling edge, outputs sampled 1 ns after the rising edge
   task automatic tick(input string tag);
      @(negedge clk);
      drive();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_outputs(tag);
   endtask

   // called right after tick(): reset pulse that lies entirely between clock edges
   task automatic async_reset(input string tag);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_outputs(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      set_in(1, 0, 0, 0, 0);
      drive();
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // disabled: sel sweeps have no effect
      for (int s = 0; s < 4; s++) begin
         set_in(0, 0, 0, s, 0);
         tick("idle_sweep");
      end

      // direct decode
      for (int s = 0; s < 4; s++) begin
         set_in(0, 1, 0, s, 0);
         tick("direct");
      end

      // scan from reset through the first wrap
      async_reset("rst_before_scan");
      set_in(0, 1, 1, 0, 0);
      repeat (17) tick("scan");

      // load on the cycle the dwell would expire
      guard = 0;
      while (m_held[0] != 4 && guard < 8) begin
         tick("scan_wait");
         guard++;
      end
      set_in(0, 1, 1, 2, 1);
      tick("load_at_last");
      set_in(0, 1, 1, 0, 0);
      repeat (5) tick("load_hold");

      // load 0 while on the last line: no wrap
      set_in(0, 1, 1, 3, 1);
      tick("load3");
      set_in(0, 1, 1, 0, 1);
      tick("load0_no_wrap");

      // freeze on line 1 and resume
      set_in(0, 1, 1, 1, 1);
      tick("load1");
      set_in(0, 1, 1, 0, 0);
      tick("line1");
      set_in(0, 0, 1, 0, 0);
      repeat (3) tick("freeze");
      set_in(0, 1, 1, 0, 0);
      repeat (5) tick("resume");

      // asynchronous reset mid-scan
      async_reset("async_rst");
      repeat (5) tick("post_rst");

      // SEL_W=3, DWELL=1 walk
      set_in(1, 1, 1, 0, 0);
      repeat (20) tick("scan8");

      // random traffic on both instances
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++)
            set_in(d, int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, nlines(d) - 1)), int'($urandom_range(0, 7) == 0));
         tick("random");
         if ($urandom_range(0, 99) == 0) async_reset("random_rst");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
